// File: rtl/wd_supervisor.sv
// rtl/wd_supervisor.sv - heartbeat-driven watchdog supervisor with bounded recovery and lockout
module wd_supervisor #(
  parameter int NUM_SRC     = 4,
  parameter int WINDOW      = 1000,
  parameter int HOLD_CYCLES = 16,
  parameter int MAX_RETRIES = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic [NUM_SRC-1:0] src_beat,
  input  logic [NUM_SRC-1:0] src_mask,
  input  logic               wd_triggered,
  input  logic               wd_warning,
  output logic               wd_enable,
  output logic               wd_heartbeat,
  output logic               wd_force_reset,
  output logic               rf_mute,
  output logic [NUM_SRC-1:0] missing,
  output logic [1:0]         retry_count,
  output logic               lockout,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    RECOVER = 2'b10,
    LOCKOUT = 2'b11
  } state_t;

  localparam int WW = $clog2(WINDOW);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] seen_q, seen_d, seen_next;
  logic [NUM_SRC-1:0] missing_q, missing_d;
  logic [WW-1:0]      win_q, win_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [1:0]         retry_q, retry_d;
  logic               en_q, en_d, hb_q, hb_d, force_q, force_d;
  logic               mute_q, mute_d, lock_q, lock_d;
  logic               kick;

  assign seen_next = seen_q | (src_beat & src_mask);
  // Masked-off sources read as present so only participating ones gate the kick.
  assign kick = (|src_mask) && (&(seen_next | ~src_mask));

  always_comb begin
    state_d   = state_q;
    seen_d    = seen_q;
    win_d     = win_q;
    hold_d    = hold_q;
    retry_d   = retry_q;
    missing_d = missing_q;
    hb_d      = 1'b0;
    if (!arm) begin
      state_d = IDLE;
      seen_d  = '0;
      win_d   = '0;
      hold_d  = '0;
      retry_d = 2'd0;
    end else begin
      case (state_q)
        IDLE: state_d = ARMED;
        ARMED: begin
          if (wd_triggered) begin
            state_d = RECOVER;
            seen_d  = '0;
            win_d   = '0;
            hold_d  = '0;
            retry_d = (retry_q == 2'd3) ? retry_q : retry_q + 2'd1;
          end else if (kick) begin
            hb_d      = 1'b1;
            seen_d    = '0;
            win_d     = '0;
            retry_d   = 2'd0;
            missing_d = '0;
          end else if (win_q == WW'(WINDOW - 1)) begin
            missing_d = src_mask & ~seen_next;
            seen_d    = '0;
            win_d     = '0;
          end else begin
            seen_d = seen_next;
            win_d  = win_q + WW'(1);
          end
        end
        RECOVER: begin
          if (hold_q == HW'(HOLD_CYCLES - 1)) begin
            hold_d  = '0;
            state_d = (retry_q >= 2'(MAX_RETRIES)) ? LOCKOUT : ARMED;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        default: state_d = LOCKOUT;
      endcase
    end
    // Outputs are registered from the next state so they line up with the state code.
    en_d    = (state_d == ARMED);
    force_d = (state_d == RECOVER) || (state_d == LOCKOUT);
    mute_d  = force_d || ((state_d == ARMED) && wd_warning);
    lock_d  = (state_d == LOCKOUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      seen_q    <= '0;
      missing_q <= '0;
      win_q     <= '0;
      hold_q    <= '0;
      retry_q   <= 2'd0;
      en_q      <= 1'b0;
      hb_q      <= 1'b0;
      force_q   <= 1'b0;
      mute_q    <= 1'b0;
      lock_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      seen_q    <= seen_d;
      missing_q <= missing_d;
      win_q     <= win_d;
      hold_q    <= hold_d;
      retry_q   <= retry_d;
      en_q      <= en_d;
      hb_q      <= hb_d;
      force_q   <= force_d;
      mute_q    <= mute_d;
      lock_q    <= lock_d;
    end
  end

  assign wd_enable      = en_q;
  assign wd_heartbeat   = hb_q;
  assign wd_force_reset = force_q;
  assign rf_mute        = mute_q;
  assign missing        = missing_q;
  assign retry_count    = retry_q;
  assign lockout        = lock_q;
  assign state          = state_q;

endmodule

// File: tb/tb_wd_supervisor.sv
// tb/tb_wd_supervisor.sv - directed scoreboard bench for wd_supervisor
module tb_wd_supervisor;

  localparam int S_STATE = 0, S_EN = 1, S_HB = 2, S_FORCE = 3;
  localparam int S_MUTE = 4, S_MISS = 5, S_RETRY = 6, S_LOCK = 7;

  typedef struct {
    int         cyc;
    int         sel;
    logic [3:0] val;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, arm, wd_triggered, wd_warning;
  logic [3:0] src_beat, src_mask;
  logic       wd_enable, wd_heartbeat, wd_force_reset, rf_mute, lockout;
  logic [3:0] missing;
  logic [1:0] retry_count, state;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic done = 1'b0;
  exp_t sb[$];

  wd_supervisor #(.NUM_SRC(4), .WINDOW(20), .HOLD_CYCLES(16), .MAX_RETRIES(3)) dut (
    .clk(clk), .rst(rst), .arm(arm), .src_beat(src_beat), .src_mask(src_mask),
    .wd_triggered(wd_triggered), .wd_warning(wd_warning), .wd_enable(wd_enable),
    .wd_heartbeat(wd_heartbeat), .wd_force_reset(wd_force_reset), .rf_mute(rf_mute),
    .missing(missing), .retry_count(retry_count), .lockout(lockout), .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic exp_at(input int d, input int sel, input logic [3:0] v, input string n);
    exp_t e;
    e.cyc = cyc + d; e.sel = sel; e.val = v; e.name = n;
    sb.push_back(e);
  endtask

  function automatic logic [3:0] actual(input int sel);
    case (sel)
      S_STATE: return {2'b00, state};
      S_EN:    return {3'b000, wd_enable};
      S_HB:    return {3'b000, wd_heartbeat};
      S_FORCE: return {3'b000, wd_force_reset};
      S_MUTE:  return {3'b000, rf_mute};
      S_MISS:  return missing;
      S_RETRY: return {2'b00, retry_count};
      default: return {3'b000, lockout};
    endcase
  endfunction

  // Monitor: every expectation whose cycle has arrived is compared at the falling edge.
  always @(negedge clk) begin
    logic [3:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        checks++;
        act = actual(sb[i].sel);
        if (sb[i].cyc < cyc || act !== sb[i].val) begin
          failures++;
          $display("FAIL %s cyc=%0d actual=%0h required=%0h", sb[i].name, sb[i].cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
    if (done) begin
      foreach (sb[i]) begin
        checks++;
        failures++;
        $display("FAIL %s never sampled (cyc=%0d)", sb[i].name, sb[i].cyc);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; arm = 1'b0; src_beat = 4'h0; src_mask = 4'h0;
    wd_triggered = 1'b0; wd_warning = 1'b0;
    tick();
    exp_at(0, S_STATE, 4'h0, "rst_state");  exp_at(0, S_EN, 4'h0, "rst_enable");
    exp_at(0, S_HB, 4'h0, "rst_hb");        exp_at(0, S_FORCE, 4'h0, "rst_force");
    exp_at(0, S_MUTE, 4'h0, "rst_mute");    exp_at(0, S_MISS, 4'h0, "rst_missing");
    exp_at(0, S_RETRY, 4'h0, "rst_retry");  exp_at(0, S_LOCK, 4'h0, "rst_lockout");
    tick(); rst = 1'b0; tick();

    // Staggered beats on all four sources
    arm = 1'b1; src_mask = 4'hF;
    exp_at(0, S_STATE, 4'h0, "idle_before_arm");
    exp_at(1, S_STATE, 4'h1, "armed_state"); exp_at(1, S_EN, 4'h1, "armed_enable");
    tick();
    for (int i = 0; i < 4; i++) begin
      src_beat = 4'(1 << i);
      if (i == 3) begin
        exp_at(0, S_HB, 4'h0, "hb_not_early");
        exp_at(1, S_HB, 4'h1, "kick_hb");
        exp_at(2, S_HB, 4'h0, "kick_hb_single");
        exp_at(1, S_MISS, 4'h0, "kick_missing");
      end
      tick();
    end
    src_beat = 4'h0;

    // Only sources 0,1 beat: window expires with 1100 missing
    src_beat = 4'h1; tick(); src_beat = 4'h2; tick(); src_beat = 4'h0;
    for (int d = 1; d <= 18; d++) exp_at(d, S_HB, 4'h0, "partial_no_kick");
    exp_at(17, S_MISS, 4'h0, "miss_before_expiry");
    exp_at(18, S_MISS, 4'hC, "miss_after_expiry");
    exp_at(18, S_EN, 4'h1, "en_after_expiry");
    tick_n(18);

    // Burst kick clears missing, then final beat lands on the expiry cycle
    src_beat = 4'hF;
    exp_at(1, S_HB, 4'h1, "burst_kick"); exp_at(1, S_MISS, 4'h0, "burst_clears_missing");
    tick();
    src_beat = 4'h7; tick(); src_beat = 4'h0;
    tick_n(18);
    src_beat = 4'h8;
    exp_at(0, S_HB, 4'h0, "expiry_no_early_hb");
    exp_at(1, S_HB, 4'h1, "expiry_edge_kick");
    exp_at(1, S_MISS, 4'h0, "expiry_edge_missing");
    tick(); src_beat = 4'h0;

    // Masking
    src_mask = 4'h3; src_beat = 4'hC;
    exp_at(1, S_HB, 4'h0, "masked_beats_ignored");
    tick();
    src_beat = 4'h3;
    exp_at(1, S_HB, 4'h1, "masked_kick");
    tick();
    src_mask = 4'h0; src_beat = 4'hF;
    for (int d = 1; d <= 22; d++) exp_at(d, S_HB, 4'h0, "mask0_no_kick");
    exp_at(22, S_EN, 4'h1, "mask0_enabled");
    tick_n(22);
    src_beat = 4'h0; src_mask = 4'hF;

    // Warning mutes without a state change
    wd_warning = 1'b1;
    exp_at(1, S_MUTE, 4'h1, "warn_mute"); exp_at(1, S_STATE, 4'h1, "warn_state");
    tick(); wd_warning = 1'b0;
    exp_at(1, S_MUTE, 4'h0, "warn_release");
    tick();

    // First recovery
    wd_triggered = 1'b1;
    exp_at(1, S_RETRY, 4'h1, "retry1");
    for (int d = 1; d <= 16; d++) exp_at(d, S_STATE, 4'h2, "recover_state");
    exp_at(1, S_FORCE, 4'h1, "recover_force"); exp_at(16, S_MUTE, 4'h1, "recover_mute");
    exp_at(8, S_EN, 4'h0, "recover_enable");
    exp_at(17, S_STATE, 4'h1, "recover_done"); exp_at(17, S_FORCE, 4'h0, "recover_force_off");
    exp_at(17, S_MUTE, 4'h0, "recover_mute_off"); exp_at(17, S_EN, 4'h1, "recover_enable_on");
    tick(); wd_triggered = 1'b0; tick_n(16);

    // Second and third trigger lead to lockout
    wd_triggered = 1'b1;
    exp_at(1, S_RETRY, 4'h2, "retry2");
    tick(); wd_triggered = 1'b0; tick_n(16);
    exp_at(0, S_STATE, 4'h1, "armed_after_2");
    wd_triggered = 1'b1;
    exp_at(1, S_RETRY, 4'h3, "retry3");
    exp_at(16, S_STATE, 4'h2, "recover3_last");
    exp_at(17, S_STATE, 4'h3, "lockout_state"); exp_at(17, S_LOCK, 4'h1, "lockout_flag");
    exp_at(17, S_FORCE, 4'h1, "lockout_force"); exp_at(17, S_MUTE, 4'h1, "lockout_mute");
    exp_at(17, S_EN, 4'h0, "lockout_enable");
    tick(); wd_triggered = 1'b0; tick_n(20);
    exp_at(0, S_LOCK, 4'h1, "lockout_held");
    arm = 1'b0;
    exp_at(1, S_STATE, 4'h0, "lock_exit_idle"); exp_at(1, S_RETRY, 4'h0, "lock_exit_retry");
    exp_at(1, S_LOCK, 4'h0, "lock_exit_flag"); exp_at(1, S_MUTE, 4'h0, "lock_exit_mute");
    exp_at(1, S_FORCE, 4'h0, "lock_exit_force");
    tick(); tick();

    // Reset in the fourth hold cycle
    arm = 1'b1; tick();
    wd_triggered = 1'b1; tick(); wd_triggered = 1'b0;
    tick_n(2);
    exp_at(0, S_STATE, 4'h2, "in_recover");
    tick();
    rst = 1'b1;
    exp_at(0, S_STATE, 4'h0, "midrst_state"); exp_at(0, S_EN, 4'h0, "midrst_enable");
    exp_at(0, S_FORCE, 4'h0, "midrst_force"); exp_at(0, S_MUTE, 4'h0, "midrst_mute");
    exp_at(0, S_RETRY, 4'h0, "midrst_retry"); exp_at(0, S_LOCK, 4'h0, "midrst_lock");
    exp_at(0, S_HB, 4'h0, "midrst_hb");       exp_at(0, S_MISS, 4'h0, "midrst_missing");
    tick(); rst = 1'b0;
    exp_at(1, S_STATE, 4'h1, "rearm_state"); exp_at(1, S_RETRY, 4'h0, "rearm_retry");
    tick(); tick();

    // arm=0 beats a simultaneous trigger
    arm = 1'b0; wd_triggered = 1'b1;
    exp_at(1, S_STATE, 4'h0, "arm_priority"); exp_at(1, S_FORCE, 4'h0, "arm_priority_force");
    tick(); wd_triggered = 1'b0;
    tick_n(3);
    done = 1'b1;
  end

endmodule
